// File: rtl/circuito_jogo_param_if.sv
// circuito_jogo_param_if: player-side and debug signals of the memory game
interface circuito_jogo_param_if #(
   parameter int N_CHAVES = 4,
   parameter int DEPTH    = 16
);
   localparam int CW = $clog2(DEPTH);
   logic                iniciar;
   logic [N_CHAVES-1:0] chaves;
   logic                acertou;
   logic                errou;
   logic                pronto;
   logic [N_CHAVES-1:0] leds;
   logic                db_igual;
   logic [CW-1:0]       db_contagem;
   logic [CW-1:0]       db_rodada;
   logic [N_CHAVES-1:0] db_memoria;
   logic [3:0]          db_estado;
   logic                db_tem_jogada;
   logic                db_timeout;
   modport master (
      output iniciar, chaves,
      input  acertou, errou, pronto, leds, db_igual, db_contagem, db_rodada,
             db_memoria, db_estado, db_tem_jogada, db_timeout
   );
   modport slave (
      input  iniciar, chaves,
      output acertou, errou, pronto, leds, db_igual, db_contagem, db_rodada,
             db_memoria, db_estado, db_tem_jogada, db_timeout
   );
endinterface

// File: rtl/circuito_jogo_param.sv
// circuito_jogo_param: growing-sequence memory game, control and datapath merged; optional timeout via JOGO_TIMEOUT_EN
module circuito_jogo_param #(
   parameter int N_CHAVES = 4,
   parameter int DEPTH    = 16,
   parameter int TIMEOUT  = 5000
) (
   input logic                  clock,
   input logic                  reset,
   circuito_jogo_param_if.slave bus
);
   localparam int CW = $clog2(DEPTH);
   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h3,
      COMPARA     = 4'h4,
      PROX_JOGADA = 4'h5,
      PROX_RODADA = 4'h6,
      FIM_ACERTO  = 4'hA,
      FIM_TIMEOUT = 4'hD,
      FIM_ERRO    = 4'hE
   } t_estado;
   t_estado             r_estado, w_prox;
   logic [CW-1:0]       r_contagem, r_rodada;
   logic [N_CHAVES-1:0] r_jogada, r_chaves_q, w_mem;
   logic                w_igual, w_jogada_feita, w_tmo_fim;
   logic [N_CHAVES-1:0] w_rom [DEPTH];
   if (DEPTH < 2 || TIMEOUT < 2) begin : g_param_check
      $error("circuito_jogo_param: DEPTH and TIMEOUT must be >= 2");
   end
   for (genvar g = 0; g < DEPTH; g++) begin : g_rom
      assign w_rom[g] = N_CHAVES'(1) << (g % N_CHAVES);
   end
   assign w_mem          = w_rom[r_contagem];
   assign w_igual        = r_jogada == w_mem;
   assign w_jogada_feita = (bus.chaves != '0) && (r_chaves_q == '0);
`ifdef JOGO_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] r_tmo;
   // count consecutive ESPERA cycles; any exit from ESPERA restarts the count
   always_ff @(posedge clock)
      if (reset || r_estado != ESPERA || w_prox != ESPERA) r_tmo <= '0;
      else r_tmo <= r_tmo + 1'b1;
   assign w_tmo_fim      = r_tmo == TW'(TIMEOUT - 1);
   assign bus.db_timeout = r_estado == FIM_TIMEOUT;
`else
   assign w_tmo_fim      = 1'b0;
   assign bus.db_timeout = 1'b0;
`endif
   // state register
   always_ff @(posedge clock)
      r_estado <= reset ? INICIAL : w_prox;
   // next-state logic; a press wins over the timeout bound in the same cycle
   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         INICIAL:                           w_prox = bus.iniciar ? PREPARA : INICIAL;
         PREPARA:                           w_prox = ESPERA;
         ESPERA:                            w_prox = w_jogada_feita ? REGISTRA : w_tmo_fim ? FIM_TIMEOUT : ESPERA;
         REGISTRA:                          w_prox = COMPARA;
         COMPARA:                           w_prox = !w_igual ? FIM_ERRO :
                                                     r_contagem < r_rodada ? PROX_JOGADA :
                                                     r_rodada == CW'(DEPTH - 1) ? FIM_ACERTO : PROX_RODADA;
         PROX_JOGADA, PROX_RODADA:          w_prox = ESPERA;
         FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: w_prox = bus.iniciar ? PREPARA : r_estado;
         default:                           w_prox = INICIAL;
      endcase
   end
   // key history for press-edge detection
   always_ff @(posedge clock)
      r_chaves_q <= reset ? '0 : bus.chaves;
   // round/position counters and the captured jogada
   always_ff @(posedge clock)
      if (reset || r_estado == PREPARA) begin
         r_contagem <= '0;
         r_rodada   <= '0;
         r_jogada   <= '0;
      end else begin
         if (r_estado == REGISTRA) r_jogada <= bus.chaves;
         if (r_estado == PROX_JOGADA) r_contagem <= r_contagem + 1'b1;
         if (r_estado == PROX_RODADA) begin
            r_rodada   <= r_rodada + 1'b1;
            r_contagem <= '0;
         end
      end
   assign bus.acertou       = r_estado == FIM_ACERTO;
   assign bus.errou         = r_estado == FIM_ERRO || r_estado == FIM_TIMEOUT;
   assign bus.pronto        = bus.acertou || bus.errou;
   assign bus.leds          = r_jogada;
   assign bus.db_igual      = w_igual;
   assign bus.db_contagem   = r_contagem;
   assign bus.db_rodada     = r_rodada;
   assign bus.db_memoria    = r_estado == INICIAL ? '0 : w_mem;
   assign bus.db_estado     = r_estado;
   assign bus.db_tem_jogada = w_jogada_feita;
endmodule

// File: tb/tb_circuito_jogo_param.sv
// tb_circuito_jogo_param: directed vector table plus timeout sequences for circuito_jogo_param
module tb_circuito_jogo_param;
   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   typedef struct {
      int rst, ini, ch, tem, est, rod, cnt, leds, ig, res;
   } vec_t;
   vec_t tbl[$];
   circuito_jogo_param_if #(.N_CHAVES(4), .DEPTH(4)) bus ();
   circuito_jogo_param #(.N_CHAVES(4), .DEPTH(4), .TIMEOUT(20)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic v(input int r, i, ch, tem, est, rod, cnt, leds, ig, res);
      tbl.push_back('{r, i, ch, tem, est, rod, cnt, leds, ig, res});
   endtask
   task automatic play01(input bit whole);
      v(0,0,1,1, 3,0,0,0,0,0);
      v(0,0,1,0, 4,0,0,1,1,0);
      v(0,0,0,0, 6,0,0,1,1,0);
      v(0,0,0,0, 2,1,0,1,1,0);
      v(0,0,1,1, 3,1,0,1,1,0);
      v(0,0,1,0, 4,1,0,1,1,0);
      v(0,0,0,0, 5,1,0,1,1,0);
      v(0,0,0,0, 2,1,1,1,0,0);
      if (whole) begin
         v(0,0,2,1, 3,1,1,1,0,0);
         v(0,0,2,0, 4,1,1,2,1,0);
         v(0,0,0,0, 6,1,1,2,1,0);
         v(0,0,0,0, 2,2,0,2,0,0);
      end
   endtask
   task automatic chk(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask
   initial begin
      logic [21:0] got, exp;
      logic        tem_seen;
      rst = 1'b1;
      bus.iniciar = 1'b0;
      bus.chaves = 4'd0;
      v(1,0,0,0, 0,0,0,0,0,0);
      v(1,0,0,0, 0,0,0,0,0,0);
      v(0,1,0,0, 1,0,0,0,0,0);
      v(0,0,0,0, 2,0,0,0,0,0);
      play01(1);
      v(0,0,1,1, 3,2,0,2,0,0);
      v(0,0,1,0, 4,2,0,1,1,0);
      v(0,0,0,0, 5,2,0,1,1,0);
      v(0,0,0,0, 2,2,1,1,0,0);
      v(0,0,2,1, 3,2,1,1,0,0);
      v(0,0,2,0, 4,2,1,2,1,0);
      v(0,0,0,0, 5,2,1,2,1,0);
      v(0,0,0,0, 2,2,2,2,0,0);
      v(0,0,4,1, 3,2,2,2,0,0);
      v(0,0,4,0, 4,2,2,4,1,0);
      v(0,0,0,0, 6,2,2,4,1,0);
      v(0,0,0,0, 2,3,0,4,0,0);
      v(0,0,1,1, 3,3,0,4,0,0);
      v(0,0,1,0, 4,3,0,1,1,0);
      v(0,0,0,0, 5,3,0,1,1,0);
      v(0,0,0,0, 2,3,1,1,0,0);
      v(0,0,2,1, 3,3,1,1,0,0);
      v(0,0,2,0, 4,3,1,2,1,0);
      v(0,0,0,0, 5,3,1,2,1,0);
      v(0,0,0,0, 2,3,2,2,0,0);
      v(0,0,4,1, 3,3,2,2,0,0);
      v(0,0,4,0, 4,3,2,4,1,0);
      v(0,0,0,0, 5,3,2,4,1,0);
      v(0,0,0,0, 2,3,3,4,0,0);
      v(0,0,8,1, 3,3,3,4,0,0);
      v(0,0,8,0, 4,3,3,8,1,0);
      v(0,0,0,0, 10,3,3,8,1,1);
      v(0,0,0,0, 10,3,3,8,1,1);
      v(0,1,0,0, 1,3,3,8,1,0);
      v(0,0,0,0, 2,0,0,0,0,0);
      play01(0);
      v(0,1,0,0, 2,1,1,1,0,0);
      v(0,0,4,1, 3,1,1,1,0,0);
      v(0,0,4,0, 4,1,1,4,0,0);
      v(0,0,0,0, 14,1,1,4,0,2);
      v(0,0,0,0, 14,1,1,4,0,2);
      v(0,1,0,0, 1,1,1,4,0,0);
      v(0,0,0,0, 2,0,0,0,0,0);
      v(0,0,3,1, 3,0,0,0,0,0);
      v(0,0,3,0, 4,0,0,3,0,0);
      v(0,0,3,0, 14,0,0,3,0,2);
      v(0,0,3,0, 14,0,0,3,0,2);
      v(0,0,0,0, 14,0,0,3,0,2);
      v(0,1,0,0, 1,0,0,3,0,0);
      v(0,0,0,0, 2,0,0,0,0,0);
      play01(1);
      v(1,0,0,0, 0,0,0,0,0,0);
      v(0,0,0,0, 0,0,0,0,0,0);
      v(0,1,0,0, 1,0,0,0,0,0);
      v(0,0,0,0, 2,0,0,0,0,0);
      @(negedge clk);
      foreach (tbl[i]) begin
         rst = tbl[i].rst[0];
         bus.iniciar = tbl[i].ini[0];
         bus.chaves = 4'(tbl[i].ch);
         #1 tem_seen = bus.db_tem_jogada;
         @(negedge clk);
         got = {bus.db_estado, bus.db_rodada, bus.db_contagem, bus.leds, bus.db_igual,
                bus.acertou, bus.errou, bus.pronto, tem_seen, bus.db_memoria, bus.db_timeout};
         exp = {4'(tbl[i].est), 2'(tbl[i].rod), 2'(tbl[i].cnt), 4'(tbl[i].leds), tbl[i].ig[0],
                tbl[i].res == 1, tbl[i].res == 2, tbl[i].res != 0, tbl[i].tem[0],
                tbl[i].est == 0 ? 4'd0 : 4'(1 << tbl[i].cnt), 1'b0};
         chk($sformatf("vec%0d", i), int'(got), int'(exp));
      end
`ifdef JOGO_TIMEOUT_EN
      for (int k = 2; k <= 20; k++) begin
         @(negedge clk);
         chk($sformatf("espera_obs%0d", k), int'(bus.db_estado), 2);
      end
      @(negedge clk);
      chk("timeout_estado", int'(bus.db_estado), 'hD);
      chk("timeout_flags", int'({bus.acertou, bus.errou, bus.pronto, bus.db_timeout}), 'b0111);
      bus.iniciar = 1'b1;
      @(negedge clk);
      chk("restart_tmo", int'({bus.db_estado, bus.db_timeout, bus.errou}), 'h1 << 2);
      bus.iniciar = 1'b0;
      @(negedge clk);
      chk("restart_espera", int'(bus.db_estado), 2);
      for (int k = 2; k <= 20; k++) @(negedge clk);
      chk("espera_obs20b", int'(bus.db_estado), 2);
      bus.chaves = 4'b0001;
      @(negedge clk);
      chk("press_at_bound", int'({bus.db_estado, bus.db_timeout}), 3 << 1);
      @(negedge clk);
      chk("bound_compara", int'({bus.db_estado, bus.leds}), 'h41);
      bus.chaves = 4'b0000;
      @(negedge clk);
      chk("bound_prox_rodada", int'(bus.db_estado), 6);
`else
      for (int k = 0; k < 40; k++) @(negedge clk);
      chk("no_timeout_estado", int'(bus.db_estado), 2);
      chk("no_timeout_flags", int'({bus.errou, bus.pronto, bus.db_timeout}), 0);
      bus.chaves = 4'b0001;
      @(negedge clk);
      chk("late_press", int'(bus.db_estado), 3);
      @(negedge clk);
      chk("late_compara", int'({bus.db_estado, bus.leds, bus.db_igual}), ('h41 << 1) | 1);
      bus.chaves = 4'b0000;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
